line_fill_responder: RTL and testbench
======================================

# line_fill_responder

Main-memory-side responder for the data cache's line-fill path: it accepts one request at a time from the cache controller and serves reads as a multi-word line burst after a fixed access latency. It also serves single-word write-through stores with a one-beat acknowledge. It replaces the zero-latency combinational memory read behind the direct-mapped cache, so cache refill logic can be exercised against realistic latency and backpressure.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 32, byte address width
- WORDS_PER_LINE, 4, beats per read burst; power of two, ≥2
- LATENCY, 3, cycles from request accept to first response beat; ≥1
- MEM_WORDS, 1024, storage depth in words; power of two

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = single-word write, 0 = line read
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- req_wdata  in  DATA_WIDTH  write data, used when req_we = 1
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  cache can take the beat
- rsp_data  out  DATA_WIDTH  beat data
- rsp_last  out  1  final beat of the response

## Operation
- Word index: req_addr[log2(MEM_WORDS)+1:2]. Line base: the word index with its low log2(WORDS_PER_LINE) bits cleared. Higher address bits alias.
- States:
  - IDLE → WAIT on accept (req_valid && req_ready).
  - WAIT → BURST for a read, or WAIT → WACK for a write, when the latency counter reaches LATENCY.
  - BURST → IDLE on a transfer with rsp_last = 1.
  - WACK → IDLE on a transfer.
- Write: the storage word is updated at the accept edge. WACK presents rsp_data = the written word and rsp_last = 1.
- Read: the burst presents WORDS_PER_LINE beats in word order, wrapping modulo WORDS_PER_LINE within the line. rsp_last = 1 only on the final beat. Data is sampled from storage as each beat is loaded, so a write accepted earlier is always visible to later reads.
- A beat is held stable (valid, data, last) until rsp_valid && rsp_ready.
- The beat counter and the latency counter are log2-sized and wrap naturally; no arithmetic overflow is possible.
- Reset values, all outputs registered: req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_last = 0; state = IDLE, counters = 0.
  - Storage contents are not reset.
  - req_ready rises at the first clock edge after rst_n deasserts.
- Reset mid-operation (WAIT, BURST or WACK): aborts immediately, with outputs at their reset values. A write accepted before reset remains in storage. No response is owed after reset.

## Timing
- Accept at edge k:
  - req_ready falls at edge k.
  - The first rsp_valid rises at edge k+LATENCY.
- With rsp_ready held high, a read occupies LATENCY+WORDS_PER_LINE cycles from the accept edge. Beats appear on consecutive cycles.
- At the transfer edge of the final beat, rsp_valid falls and req_ready rises. The minimum request-to-request spacing is therefore LATENCY+WORDS_PER_LINE+1 cycles.
- req_valid asserted while req_ready = 0 is ignored. The cache must hold the request until it is accepted.
- rsp_ready low stalls the burst indefinitely with no loss of beats.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: the read burst starts at the requested word and wraps through the line. Example: WORDS_PER_LINE = 4, requested word 2 → order 2, 3, 0, 1.
- Not defined: the burst always starts at the line base (order 0, 1, 2, 3), regardless of the requested word.
- Writes are unaffected by the macro.

## Structure
- Package line_fill_pkg:
  - state enum (IDLE, WAIT, BURST, WACK)
  - localparam-derived widths: index width, beat-counter width, latency-counter width
- Sub-module resp_word_ram:
  - single-port, word-addressed storage array
  - synchronous write, combinational read
  - no reset
- The FSM, counters and output registers stay in line_fill_responder.

## Test plan
- Reset: assert rst_n low mid-burst → all outputs 0 within the same cycle. req_ready = 1 one edge after release. No further beats.
- Write then read: write 0xDEADBEEF at address 0x18, then read 0x10 with rsp_ready = 1 → ack beat 0xDEADBEEF with rsp_last = 1 after 3 cycles. Read returns words 4–7 with word 6 = 0xDEADBEEF, rsp_last on beat 4, first beat 3 cycles after accept.
- Critical word first: read address 0x18 → beat order words 6, 7, 4, 5 when CRITICAL_WORD_FIRST_EN is defined; 4, 5, 6, 7 when it is not.
- Backpressure: rsp_ready low for 5 cycles during beat 2 → beat 2 held stable with identical data throughout. Total beats = 4, none dropped or duplicated.
- Busy rejection: second req_valid held from the cycle after accept → not accepted until req_ready rises after the last-beat transfer. It is then accepted on the first cycle req_ready is high.
- Aliasing/wrap: write to word index MEM_WORDS−1, then read address (MEM_WORDS−1)·4 + MEM_WORDS·4 → same word returned.

Source files
------------

// File: rtl/line_fill_pkg.sv
// Shared types and width helpers for the line-fill responder.
package line_fill_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_LATENCY        = 3;
    localparam int DEF_MEM_WORDS      = 1024;

    function automatic int idx_w(input int mem_words);
        return $clog2(mem_words);
    endfunction

    function automatic int beat_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Must be able to hold the value LATENCY itself.
    function automatic int lat_w(input int latency);
        return $clog2(latency + 1);
    endfunction

    localparam int IDX_W  = idx_w(DEF_MEM_WORDS);
    localparam int BEAT_W = beat_w(DEF_WORDS_PER_LINE);
    localparam int LAT_W  = lat_w(DEF_LATENCY);

endpackage

// File: rtl/line_fill_responder_ram.sv
// Word-addressed backing store: synchronous write, combinational read, no reset.
module resp_word_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side line-fill responder: latency-delayed line bursts and write acks.
// Define CRITICAL_WORD_FIRST_EN to start read bursts at the requested word.
module line_fill_responder
    import line_fill_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int LATENCY        = DEF_LATENCY,
    parameter int MEM_WORDS      = DEF_MEM_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last
);

    localparam int IW = idx_w(MEM_WORDS);
    localparam int OW = beat_w(WORDS_PER_LINE);
    localparam int LW = lat_w(LATENCY);
    localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] LAT_END   = LW'(LATENCY);

    state_t          state;
    logic [IW-1:0]   line_idx;
    logic [OW-1:0]   start_off;
    logic [OW-1:0]   beat_cnt;
    logic [LW-1:0]   lat_cnt;
    logic            is_wr;

    logic [IW-1:0]   req_idx;
    logic [OW-1:0]   rd_start;
    logic [OW-1:0]   ld_off;
    logic [IW-1:0]   ld_idx;
    logic [IW-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic            accept;
    logic            xfer;
    logic            unused_addr_bits;

    assign req_idx = req_addr[IW+1:2];
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IW+2], req_addr[1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
    assign rd_start = req_idx[OW-1:0];
`else
    assign rd_start = '0;
`endif

    assign accept = req_valid && req_ready;
    assign xfer   = rsp_valid && rsp_ready;

    // Beats walk the line modulo WORDS_PER_LINE from the start offset; a write
    // reuses the same path with its own offset to read back the stored word.
    assign ld_off   = start_off + beat_cnt;
    assign ld_idx   = {line_idx[IW-1:OW], ld_off};
    assign ram_addr = (state == IDLE) ? req_idx : ld_idx;

    resp_word_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MEM_WORDS),
        .AW        (IW)
    ) u_ram (
        .clk  (clk),
        .we   (accept && req_we),
        .addr (ram_addr),
        .wdata(req_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            line_idx  <= '0;
            start_off <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
            is_wr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        line_idx  <= req_idx;
                        start_off <= req_we ? req_idx[OW-1:0] : rd_start;
                        is_wr     <= req_we;
                        beat_cnt  <= '0;
                        lat_cnt   <= LW'(1);
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_END) begin
                        state     <= is_wr ? WACK : BURST;
                        rsp_valid <= 1'b1;
                        rsp_data  <= ram_rdata;
                        rsp_last  <= is_wr || (beat_cnt == LAST_BEAT);
                        beat_cnt  <= beat_cnt + 1'b1;
                        lat_cnt   <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        if (rsp_last) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            rsp_last  <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            rsp_data <= ram_rdata;
                            rsp_last <= (beat_cnt == LAST_BEAT);
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WACK: begin
                    if (xfer) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Randomized scoreboard bench for line_fill_responder against an array memory model.
module tb_line_fill_responder;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int WPL = 4;
    localparam int LAT = 3;
    localparam int MW  = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;

    line_fill_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL),
        .LATENCY(LAT), .MEM_WORDS(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mem_m [MW];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_xfer_cyc = 0;
    int beat_no = 0;
    bit stall_req = 0;
    int stall_left = 0;
    bit rnd_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Reference: a read returns the whole line in wrap order from the start word.
    task automatic model_push(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int idx, base, start;
        beat_t b;
        idx = int'((addr >> 2) % MW);
        if (we) begin
            mem_m[idx] = wd;
            b.data = wd; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            base = idx - (idx % WPL);
`ifdef CRITICAL_WORD_FIRST_EN
            start = idx % WPL;
`else
            start = 0;
`endif
            for (int k = 0; k < WPL; k++) begin
                b.data = mem_m[base + ((start + k) % WPL)];
                b.last = (k == WPL - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, expected 1", n);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
        model_push(we, addr, wd);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_last", rsp_last, 0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        #1 chk("ready_before_edge", req_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", req_ready, 1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int unsigned w;
        if ($urandom_range(0, 3) == 0) w = MW - WPL + $urandom_range(0, WPL - 1);
        else w = $urandom_range(0, 15);
        return ($urandom & ~32'hFFF) | (w << 2) | ($urandom & 32'h3);
    endfunction

    initial begin : monitor
        bit pv = 0, pstall = 0, pl = 0;
        logic [DW-1:0] pd = '0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid && !pv) chk("first_beat_latency", cyc - acc_cyc, LAT);
                if (pstall) begin
                    chk("hold_valid", rsp_valid, 1);
                    chk("hold_data", rsp_data, pd);
                    chk("hold_last", rsp_last, pl);
                end
                if (rsp_valid) chk("busy_ready_low", req_ready, 0);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_data", rsp_data, e.data);
                        chk("beat_last", rsp_last, e.last);
                    end
                    if (rsp_last) begin
                        beat_no = 0;
                        last_xfer_cyc = cyc + 1;
                    end else beat_no++;
                end
                pstall = rsp_valid && !rsp_ready;
                pd = rsp_data; pl = rsp_last; pv = rsp_valid;
            end else begin
                pv = 0; pstall = 0; beat_no = 0;
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                rsp_ready = 1'b0; stall_left--;
            end else if (stall_req && rsp_valid && beat_no == 1) begin
                stall_req = 0; stall_left = 4; rsp_ready = 1'b0;
            end else begin
                rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : stim
        int a0, n;
        #1;
        chk("init_req_ready", req_ready, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        do_reset();

        for (int w = 0; w < 16; w++) issue(1'b1, 32'(w << 2), $urandom);
        for (int w = MW - WPL; w < MW; w++) issue(1'b1, 32'(w << 2), $urandom);
        drain();

        issue(1'b1, 32'h18, 32'hDEADBEEF);
        issue(1'b0, 32'h10, '0);
        issue(1'b0, 32'h18, '0);
        drain();

        // Top word reached through an aliased address.
        issue(1'b1, 32'((MW - 1) * 4), 32'hA11A5ED0);
        issue(1'b0, 32'((MW - 1) * 4 + MW * 4), '0);
        drain();

        stall_req = 1;
        issue(1'b0, 32'h20, '0);
        drain();
        chk("stall_consumed", stall_req, 0);

        issue(1'b0, 32'h04, '0);
        a0 = acc_cyc;
        issue(1'b0, 32'h28, '0);
        chk("b2b_accept_cycle", acc_cyc, last_xfer_cyc + 1);
        chk("b2b_spacing", acc_cyc - a0, LAT + WPL + 1);
        drain();

        rnd_ready = 1;
        for (int i = 0; i < 60; i++) issue($urandom_range(0, 2) == 0, rand_addr(), $urandom);
        drain();
        rnd_ready = 0;

        // Write survives a reset that lands in the middle of a read burst.
        issue(1'b1, 32'h34, 32'h5A5AC3C3);
        issue(1'b0, 32'h30, '0);
        n = 0;
        while (!(rsp_valid && beat_no == 2) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("reached_mid_burst", beat_no, 2);
        do_reset();
        repeat (8) @(posedge clk);
        #1 chk("no_beats_after_reset", rsp_valid, 0);
        issue(1'b0, 32'h34, '0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
